// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds column/row counters from raw
// hsync/vsync leading edges and supervises lock with error reporting.
module vga_sync_decoder #(
    parameter int   H_TOTAL      = 800,
    parameter int   H_ACTIVE     = 640,
    parameter int   H_SYNC_START = 656,
    parameter int   V_TOTAL      = 525,
    parameter int   V_ACTIVE     = 480,
    parameter int   V_SYNC_START = 490,
    parameter logic SYNC_POL     = 1'b0,
    parameter int   LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [15:0] h_pos,
    output logic [15:0] v_pos,
    output logic        active,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_count,
    output logic [1:0]  fsm_state
);

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] H_SYNC   = 16'(H_SYNC_START);
    localparam logic [15:0] H_PRE    = 16'(H_SYNC_START - 1);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] V_SYNC   = 16'(V_SYNC_START);
    localparam logic [15:0] V_PRE    = 16'(V_SYNC_START - 1);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] WD_LIMIT = 16'(2 * H_TOTAL);
    localparam logic [15:0] WD_LAST  = 16'(2 * H_TOTAL - 1);
    localparam logic [7:0]  GOOD_TGT = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  good;
    logic [7:0]  good_nxt;
    logic        hs1;
    logic        hs2;
    logic        vs1;
    logic        vs2;
    logic        h_edge;
    logic        v_edge;
    logic [15:0] h_nxt;
    logic [15:0] v_nxt;
    logic [15:0] wd_cnt;
    logic [15:0] wd_nxt;
    logic        wd_fire;
    logic        h_bad;
    logic        v_bad;
    logic        err;

    assign h_edge    = (hs1 == SYNC_POL) && (hs2 != SYNC_POL);
    assign v_edge    = (vs1 == SYNC_POL) && (vs2 != SYNC_POL);
    assign fsm_state = state;

    // h_pos/v_pos are the recovered counters themselves; edges override wrap.
    always_comb begin
        h_nxt = (h_pos == H_LAST) ? 16'd0 : h_pos + 16'd1;
        if (h_edge) begin
            h_nxt = H_SYNC;
        end
        v_nxt = v_pos;
        if (h_pos == H_LAST) begin
            v_nxt = (v_pos == V_LAST) ? 16'd0 : v_pos + 16'd1;
        end
        if (v_edge) begin
            v_nxt = V_SYNC;
        end
    end

    // Watchdog saturates after firing once so a dead link reports a single error.
    always_comb begin
        wd_nxt  = wd_cnt;
        wd_fire = !h_edge && (wd_cnt == WD_LAST);
        if (h_edge) begin
            wd_nxt = 16'd0;
        end else if (wd_cnt != WD_LIMIT) begin
            wd_nxt = wd_cnt + 16'd1;
        end
    end

    assign h_bad = h_edge && (h_pos != H_PRE);
    assign v_bad = v_edge && !((h_pos == H_LAST) && (v_pos == V_PRE));
    assign err   = (state != ST_UNLOCKED) && (h_bad || v_bad || wd_fire);

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        if (err) begin
            state_nxt = ST_UNLOCKED;
        end else begin
            case (state)
                ST_UNLOCKED: begin
                    if (v_edge) begin
                        state_nxt = ST_ACQUIRE;
                        good_nxt  = 8'd0;
                    end
                end
                ST_ACQUIRE: begin
                    if (v_edge) begin
                        good_nxt = good + 8'd1;
                        if (good_nxt >= GOOD_TGT) begin
                            state_nxt = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    state_nxt = ST_LOCKED;
                end
                default: begin
                    state_nxt = ST_UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_UNLOCKED;
            good  <= 8'd0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs1         <= ~SYNC_POL;
            hs2         <= ~SYNC_POL;
            vs1         <= ~SYNC_POL;
            vs2         <= ~SYNC_POL;
            h_pos       <= 16'd0;
            v_pos       <= 16'd0;
            wd_cnt      <= 16'd0;
            locked      <= 1'b0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            hs1         <= hsync_in;
            hs2         <= hs1;
            vs1         <= vsync_in;
            vs2         <= vs1;
            h_pos       <= h_nxt;
            v_pos       <= v_nxt;
            wd_cnt      <= wd_nxt;
            // Qualifiers use the current state so they line up with locked.
            locked      <= (state == ST_LOCKED);
            active      <= (state == ST_LOCKED) && (h_nxt < H_ACT) && (v_nxt < V_ACT);
            frame_start <= (state == ST_LOCKED) && (h_nxt == 16'd0) && (v_nxt == 16'd0);
            sync_err    <= err;
            if (err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: scaled-down raster generator, timestamp-based
// reference model, per-cycle compare of a SYNC_POL=0 and a SYNC_POL=1 build.
module tb_vga_sync_decoder;

    // Scaled-down geometry keeps each frame at 800 clocks.
    localparam int HT    = 40;
    localparam int HA    = 32;
    localparam int HS    = 33;
    localparam int HW    = 4;
    localparam int VT    = 20;
    localparam int VA    = 16;
    localparam int VS    = 17;
    localparam int LF    = 2;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic hs_tx;
    logic vs_tx;
    logic hsync0, vsync0, hsync1, vsync1;
    assign hsync0 = ~hs_tx;
    assign vsync0 = ~vs_tx;
    assign hsync1 = hs_tx;
    assign vsync1 = vs_tx;

    logic [15:0] h_pos0, v_pos0, h_pos1, v_pos1;
    logic        active0, frame_start0, locked0, sync_err0;
    logic        active1, frame_start1, locked1, sync_err1;
    logic [7:0]  err_count0, err_count1;
    logic [1:0]  fsm_state0, fsm_state1;

    vga_sync_decoder #(.H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HS), .V_TOTAL(VT),
                       .V_ACTIVE(VA), .V_SYNC_START(VS), .SYNC_POL(1'b0), .LOCK_FRAMES(LF)) dut0 (
        .clk(clk), .reset(reset), .hsync_in(hsync0), .vsync_in(vsync0),
        .h_pos(h_pos0), .v_pos(v_pos0), .active(active0), .frame_start(frame_start0),
        .locked(locked0), .sync_err(sync_err0), .err_count(err_count0), .fsm_state(fsm_state0)
    );

    vga_sync_decoder #(.H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HS), .V_TOTAL(VT),
                       .V_ACTIVE(VA), .V_SYNC_START(VS), .SYNC_POL(1'b1), .LOCK_FRAMES(LF)) dut1 (
        .clk(clk), .reset(reset), .hsync_in(hsync1), .vsync_in(vsync1),
        .h_pos(h_pos1), .v_pos(v_pos1), .active(active1), .frame_start(frame_start1),
        .locked(locked1), .sync_err(sync_err1), .err_count(err_count1), .fsm_state(fsm_state1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] h, input logic [15:0] v,
                                         input logic a, input logic f, input logic l,
                                         input logic e, input logic [7:0] c);
        return {20'd0, h, v, a, f, l, e, c};
    endfunction

    // Transmit-side raster generator; steps 1 time unit after each posedge.
    int  tx_col = 0, tx_row = 0, col_d1 = 0, col_d2 = 0, row_d1 = 0, row_d2 = 0;
    bit  gen_run = 0, hkill = 0, stretch_pend = 0, vshift_pend = 0, vshift_cur = 0;

    always @(posedge clk) begin
        if (gen_run) begin
            #1;
            col_d2 = col_d1;
            row_d2 = row_d1;
            col_d1 = tx_col;
            row_d1 = tx_row;
            if (stretch_pend && tx_col == 5) begin
                stretch_pend = 0;
            end else if (tx_col == HT - 1) begin
                tx_col = 0;
                if (tx_row == VT - 1) begin
                    tx_row      = 0;
                    vshift_cur  = vshift_pend;
                    vshift_pend = 0;
                end else begin
                    tx_row++;
                end
            end else begin
                tx_col++;
            end
            hs_tx = !hkill && tx_col >= HS && tx_col < HS + HW;
            vs_tx = tx_row >= (vshift_cur ? VS + 1 : VS) && tx_row < (vshift_cur ? VS + 3 : VS + 2);
        end
    end

    // Reference model: counters from time since last edge, lock from clean frames.
    int cyc, last_load, last_hedge, m_h, m_v, m_state, m_good, m_errc;
    int h_prev, v_prev, st_prev;
    bit have_load, ha_prev, va_prev, he_d, ve_d;
    bit m_err, m_locked, m_active, m_fs;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0; last_load = 0; last_hedge = -1; m_h = 0; m_v = 0;
            m_state = 0; m_good = 0; m_errc = 0; have_load = 0;
            ha_prev = 0; va_prev = 0; he_d = 0; ve_d = 0;
            m_err = 0; m_locked = 0; m_active = 0; m_fs = 0;
        end else begin
            cyc++;
            h_prev  = m_h;
            v_prev  = m_v;
            st_prev = m_state;
            m_err = (st_prev != 0) && ((he_d && h_prev != HS - 1) ||
                    (ve_d && !(h_prev == HT - 1 && v_prev == VS - 1)) ||
                    (cyc - last_hedge == 2 * HT + 1));
            if (he_d) begin
                have_load = 1;
                last_load = cyc;
            end
            m_h = have_load ? (HS + cyc - last_load) % HT : cyc % HT;
            if (ve_d) m_v = VS;
            else if (h_prev == HT - 1) m_v = (v_prev + 1) % VT;
            m_locked = (st_prev == 2);
            if (m_err) m_state = 0;
            else if (ve_d && m_state == 0) begin
                m_state = 1;
                m_good  = 0;
            end else if (ve_d && m_state == 1) begin
                m_good++;
                if (m_good >= LF) m_state = 2;
            end
            if (m_err && m_errc < 255) m_errc++;
            m_active = m_locked && m_h < HA && m_v < VA;
            m_fs     = m_locked && m_h == 0 && m_v == 0;
            he_d = hs_tx && !ha_prev;
            ve_d = vs_tx && !va_prev;
            if (he_d) last_hedge = cyc;
            ha_prev = hs_tx;
            va_prev = vs_tx;
        end
    end

    bit cmp_en = 0;
    bit lat_en = 0;

    always @(negedge clk) begin
        if (reset === 1'b1 && cmp_en) begin
            check("dut0 outputs", pack(h_pos0, v_pos0, active0, frame_start0, locked0, sync_err0, err_count0),
                  pack(16'(m_h), 16'(m_v), m_active, m_fs, m_locked, m_err, 8'(m_errc)));
            check("dut1 outputs", pack(h_pos1, v_pos1, active1, frame_start1, locked1, sync_err1, err_count1),
                  pack(16'(m_h), 16'(m_v), m_active, m_fs, m_locked, m_err, 8'(m_errc)));
            if (lat_en && m_locked)
                check("latency", {32'd0, h_pos0, v_pos0}, {32'd0, 16'(col_d2), 16'(row_d2)});
        end
    end

    task automatic wait_locked(input int bound, output int n);
        n = 0;
        while (locked0 !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_err(input int bound);
        int n = 0;
        while (sync_err0 !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_tx(input int row, input int col);
        int n = 0;
        while (!(tx_row == row && tx_col == col) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("tx position reached", {32'd0, 16'(tx_row), 16'(tx_col)}, {32'd0, 16'(row), 16'(col)});
    endtask

    initial begin
        int n, pulses, acnt, fcnt;
        reset = 1'b0;
        hs_tx = 1'b0;
        vs_tx = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dut0", pack(h_pos0, v_pos0, active0, frame_start0, locked0, sync_err0, err_count0), 64'd0);
        check("reset dut1", pack(h_pos1, v_pos1, active1, frame_start1, locked1, sync_err1, err_count1), 64'd0);

        // Ideal stream from (0,0): third vsync edge lands at sample 2280.
        reset   = 1'b1;
        gen_run = 1;
        cmp_en  = 1;
        wait_locked(4 * FRAME, n);
        check("lock time", 64'(n), 64'd2283);
        check("lock position", {32'd0, h_pos0, v_pos0}, {32'd0, 16'd1, 16'd17});
        lat_en = 1;
        repeat (3 * FRAME) @(negedge clk);
        lat_en = 0;
        check("ideal err_count", 64'(err_count0), 64'd0);

        // One line stretched by a clock.
        stretch_pend = 1;
        wait_err(3 * HT);
        check("stretch sync_err", 64'(sync_err0), 64'd1);
        repeat (2) @(negedge clk);
        check("stretch unlock", 64'(locked0), 64'd0);
        check("stretch err_count", 64'(err_count0), 64'd1);
        wait_locked(4 * FRAME, n);
        check("stretch relock", 64'(locked0), 64'd1);

        // hsync absent for six lines.
        wait_tx(2, 0);
        hkill  = 1;
        pulses = 0;
        for (int i = 0; i < 6 * HT; i++) begin
            @(negedge clk);
            pulses += int'(sync_err0);
        end
        hkill = 0;
        check("watchdog pulses", 64'(pulses), 64'd1);
        check("watchdog unlock", 64'(locked0), 64'd0);
        check("watchdog err_count", 64'(err_count0), 64'd2);
        wait_locked(4 * FRAME, n);
        check("watchdog relock", 64'(locked0), 64'd1);

        // Asynchronous reset mid-frame.
        wait_tx(10, 15);
        #1 reset = 1'b0;
        #1;
        check("async reset dut0", pack(h_pos0, v_pos0, active0, frame_start0, locked0, sync_err0, err_count0), 64'd0);
        check("async reset dut1", pack(h_pos1, v_pos1, active1, frame_start1, locked1, sync_err1, err_count1), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_locked(4 * FRAME, n);
        check("reset relock", 64'(locked0), 64'd1);

        // One full locked frame, then a vsync shifted by a line.
        n = 0;
        while (frame_start0 !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        lat_en = 1;
        acnt   = 0;
        fcnt   = 0;
        for (int i = 0; i < FRAME; i++) begin
            acnt += int'(active0);
            fcnt += int'(frame_start0);
            @(negedge clk);
        end
        lat_en = 0;
        check("active count", 64'(acnt), 64'(HA * VA));
        check("frame_start count", 64'(fcnt), 64'd1);
        vshift_pend = 1;
        wait_err(3 * FRAME);
        check("vshift sync_err", 64'(sync_err0), 64'd1);
        repeat (2) @(negedge clk);
        check("vshift unlock", 64'(locked0), 64'd0);
        check("vshift err_count dut0", 64'(err_count0), 64'd1);
        check("vshift err_count dut1", 64'(err_count1), 64'd1);

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
